pipeline_ctrl: RTL and testbench

//   Central stall/flush controller for the 5-stage RISC-V core; drives the stall[5:0] vector consumed by

---
 rtl/pipeline_ctrl.sv | 105 ++++++++++
 tb/tb_pipeline_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: zero-cycle request->stall/flush; only FSM, watchdog and counter are registered.
// Backpressure: MEM wait freezes PC..MEM, EX busy freezes PC..EX, load-use freezes PC..ID; memory timeout freezes all until reset.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 256,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stallreq,
    input  logic             ex_stallreq,
    input  logic             mem_req,
    input  logic             mem_ack,
    input  logic             ex_branch_taken,
    input  logic [31:0]      ex_branch_target,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      flush_pc,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, MEM_WAIT, MEM_ERR} state_t;

    state_t           state_q;
    logic [WC_W-1:0]  wait_cnt_q;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_cycles_q;
    logic [CNT_W-1:0] stall_cycles_d;
    logic             mem_stall;

    always_comb begin
        mem_stall = 1'b0;
        case (state_q)
            IDLE:     mem_stall = mem_req & ~mem_ack;
            MEM_WAIT: mem_stall = ~mem_ack;
            default:  mem_stall = 1'b0;
        endcase
    end

    // Gating with rst makes the outputs drop the instant reset is asserted, whatever the inputs hold.
    always_comb begin
        stall = 6'b000000;
        if (rst)
            stall = 6'b000000;
        else if (state_q == MEM_ERR)
            stall = 6'b111111;
        else if (mem_stall)
            stall = 6'b011111;
        else if (ex_stallreq)
            stall = 6'b001111;
        else if (ex_branch_taken)
            stall = 6'b000000;
        else if (id_stallreq)
            stall = 6'b000111;
    end

    assign flush    = ~rst & ex_branch_taken & ~mem_stall & ~ex_stallreq & (state_q != MEM_ERR);
    assign flush_pc = flush ? ex_branch_target : 32'h0;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if ((stall != 6'b000000) && (stall_cycles_q != {CNT_W{1'b1}}))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            wait_cnt_q     <= '0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            case (state_q)
                IDLE: begin
                    if (mem_req && !mem_ack) begin
                        state_q    <= MEM_WAIT;
                        wait_cnt_q <= '0;
                    end
                end
                MEM_WAIT: begin
                    // A late ack beats the watchdog in the same cycle.
                    if (mem_ack) begin
                        state_q    <= IDLE;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q   <= MEM_ERR;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                MEM_ERR: mem_err_q <= 1'b1;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl with a short memory timeout so the watchdog path is reachable.
module tb_pipeline_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stallreq, ex_stallreq, mem_req, mem_ack, ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mem_err;
    logic [31:0] stall_cycles;

    pipeline_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_stallreq      (id_stallreq),
        .ex_stallreq      (ex_stallreq),
        .mem_req          (mem_req),
        .mem_ack          (mem_ack),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .stall            (stall),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .mem_err          (mem_err),
        .stall_cycles     (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id, ex, mreq, mack, br;
        logic [31:0] tgt;
        logic [5:0]  st;
        logic        fl;
        logic [31:0] pc;
        logic        err;
    } vec_t;

    vec_t        sb_q[$];
    vec_t        tbl[10];
    int          pass_cnt = 0;
    int          tot_cnt  = 0;
    logic [31:0] exp_cnt  = 0;
    logic        m_wait   = 1'b0;

    function automatic vec_t mk(logic id, logic ex, logic mreq, logic mack, logic br,
                                logic [31:0] tgt, logic [5:0] st, logic fl, logic [31:0] pc, logic err);
        vec_t v;
        v.id = id; v.ex = ex; v.mreq = mreq; v.mack = mack; v.br = br; v.tgt = tgt;
        v.st = st; v.fl = fl; v.pc = pc; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle of stimulus, then score the popped expectation at the falling edge.
    task automatic step(input vec_t v, input string name);
        vec_t e;
        @(posedge clk); #1;
        assert (!(m_wait && !v.mreq)) else $error("illegal mem_req drop while waiting");
        id_stallreq = v.id; ex_stallreq = v.ex; mem_req = v.mreq; mem_ack = v.mack;
        ex_branch_taken = v.br; ex_branch_target = v.tgt;
        sb_q.push_back(v);
        @(negedge clk);
        e = sb_q.pop_front();
        chk({name, ".stall"}, {26'h0, stall}, {26'h0, e.st});
        chk({name, ".flush"}, {31'h0, flush}, {31'h0, e.fl});
        chk({name, ".flush_pc"}, flush_pc, e.pc);
        chk({name, ".mem_err"}, {31'h0, mem_err}, {31'h0, e.err});
        chk({name, ".stall_cycles"}, stall_cycles, exp_cnt);
        if (e.st != 6'h0 && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        if (e.mreq && e.mack) m_wait = 1'b0;
        else if (e.mreq && e.st == 6'h1F) m_wait = 1'b1;
    endtask

    task automatic idle_inputs();
        id_stallreq = 0; ex_stallreq = 0; mem_req = 0; mem_ack = 0;
        ex_branch_taken = 0; ex_branch_target = 32'h0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst.stall", {26'h0, stall}, 32'h0);
        chk("rst.flush", {31'h0, flush}, 32'h0);
        chk("rst.mem_err", {31'h0, mem_err}, 32'h0);
        chk("rst.stall_cycles", stall_cycles, 32'h0);
        @(negedge clk);
        idle_inputs();
        exp_cnt = 0;
        m_wait  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        tbl[0] = mk(1,0,0,0,0, 32'h0,         6'h07, 0, 32'h0,         0);
        tbl[1] = mk(0,0,0,0,0, 32'h0,         6'h00, 0, 32'h0,         0);
        tbl[2] = mk(0,1,0,0,0, 32'h0,         6'h0F, 0, 32'h0,         0);
        tbl[3] = mk(1,0,0,0,1, 32'h0000_0100, 6'h00, 1, 32'h0000_0100, 0);
        tbl[4] = mk(1,1,0,0,1, 32'h0000_0100, 6'h0F, 0, 32'h0,         0);
        tbl[5] = mk(0,0,1,1,0, 32'h0,         6'h00, 0, 32'h0,         0);
        tbl[6] = mk(0,0,1,1,1, 32'hDEAD_BEEF, 6'h00, 1, 32'hDEAD_BEEF, 0);
        tbl[7] = mk(0,1,1,1,0, 32'h0,         6'h0F, 0, 32'h0,         0);
        tbl[8] = mk(1,1,0,0,0, 32'h0,         6'h0F, 0, 32'h0,         0);
        tbl[9] = mk(0,0,0,0,1, 32'h1234_5678, 6'h00, 1, 32'h1234_5678, 0);

        #12;
        chk("reset.stall", {26'h0, stall}, 32'h0);
        chk("reset.mem_err", {31'h0, mem_err}, 32'h0);
        chk("reset.stall_cycles", stall_cycles, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) step(tbl[i], $sformatf("tbl%0d", i));
        step(mk(0,0,0,0,0, 32'h0, 6'h00, 0, 32'h0, 0), "tbl_tail");

        // Ack on the fourth cycle; a branch during the wait must not flush.
        step(mk(0,0,1,0,0, 32'h0,  6'h1F, 0, 32'h0, 0), "ack.c1");
        step(mk(0,0,1,0,1, 32'h40, 6'h1F, 0, 32'h0, 0), "ack.c2");
        step(mk(0,1,1,0,0, 32'h0,  6'h1F, 0, 32'h0, 0), "ack.c3");
        step(mk(0,0,1,1,0, 32'h0,  6'h00, 0, 32'h0, 0), "ack.c4");
        step(mk(0,0,0,0,0, 32'h0,  6'h00, 0, 32'h0, 0), "ack.idle");
        step(mk(1,0,0,0,0, 32'h0,  6'h07, 0, 32'h0, 0), "ack.id");

        // Watchdog: one IDLE cycle plus TMO waiting cycles, then error lock.
        for (int i = 0; i <= TMO; i++)
            step(mk(0,0,1,0,0, 32'h0, 6'h1F, 0, 32'h0, 0), $sformatf("tmo.wait%0d", i));
        for (int i = 0; i < 3; i++)
            step(mk(0,0,1,0,1, 32'h80, 6'h3F, 0, 32'h0, 1), $sformatf("tmo.err%0d", i));
        step(mk(0,0,1,1,0, 32'h0, 6'h3F, 0, 32'h0, 1), "tmo.late_ack");
        do_reset();
        step(mk(0,0,0,0,0, 32'h0, 6'h00, 0, 32'h0, 0), "post_err");

        // Async reset while waiting on memory, with mem_req still asserted.
        step(mk(0,0,1,0,0, 32'h0, 6'h1F, 0, 32'h0, 0), "rstw.c1");
        step(mk(0,0,1,0,0, 32'h0, 6'h1F, 0, 32'h0, 0), "rstw.c2");
        do_reset();
        step(mk(0,0,0,1,0, 32'h0, 6'h00, 0, 32'h0, 0), "rstw.stray_ack");
        step(mk(0,0,0,0,0, 32'h0, 6'h00, 0, 32'h0, 0), "rstw.idle");
        step(mk(0,1,0,0,0, 32'h0, 6'h0F, 0, 32'h0, 0), "rstw.ex");
        step(mk(0,0,0,0,0, 32'h0, 6'h00, 0, 32'h0, 0), "rstw.end");

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
